pcs_rx_sync: RTL
================

Name: pcs_rx_sync

Overview:
- 1000BASE-X PCS receive synchronization controller; sits between the 10b deserializer and the PCS receive state machine.
- Runs the code-group synchronization FSM: comma alignment, even/odd tracking, loss-of-sync hysteresis.
- Produces the 11-bit SUDI word (code-group plus rx_even) and the sync_status flag that drive the receive state machine.

Parameters:
- GOOD_CGS_TARGET, 3, count of consecutive good code-groups in an "A" state required to climb one hysteresis level (fits in 2 bits).

Ports:
- clk  input  1  single clock; one code-group per cycle.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- rx_code_group  input  10  received 10b code-group; bit 9 = a, bit 0 = j.
- signal_detect  input  1  PMD signal present; low forces loss of sync.
- SUDI  output  11  registered {code_group[9:0], rx_even}; bit 0 = rx_even.
- sync_status  output  1  1 = OK (any SYNC_ACQUIRED state), 0 = FAIL.

Behaviour:
- Registered datapath, latency 1 cycle. On each posedge, code-group X and the current state/rx_even produce next_state and rx_even_new. The bench sees SUDI <= {X, rx_even_new} and sync_status <= (next_state in SYNC_ACQUIRED_*).
- Reset: state = LOSS_OF_SYNC, rx_even = 0, good_cgs = 0, SUDI = 0, sync_status = 0. Reset mid-acquisition discards all progress.
- Classification of X:
  - comma = (X[9:3] == 7'b0011111) or (X[9:3] == 7'b1100000).
  - valid = X is in the shared code table.
  - D = valid data code-group.
  - cgbad = !valid or (comma and rx_even == 1), using rx_even before update.
  - cggood = !cgbad.
- rx_even_new: "toggle" states set !rx_even; COMMA_DETECT_* states set 1.
- States and transitions, evaluated on X:
  - LOSS_OF_SYNC (toggle): signal_detect and comma -> COMMA_DETECT_1; else stay.
  - COMMA_DETECT_n (n = 1..3, set 1): D -> ACQUIRE_SYNC_n (n = 1, 2) or SYNC_ACQUIRED_1 (n = 3); else LOSS_OF_SYNC.
  - ACQUIRE_SYNC_n (n = 1, 2, toggle): evaluated in this order:
    - cgbad -> LOSS_OF_SYNC.
    - comma with rx_even == 0 -> COMMA_DETECT_n+1.
    - else stay.
  - SYNC_ACQUIRED_1 (toggle): cgbad -> SYNC_ACQUIRED_2; else stay.
  - SYNC_ACQUIRED_k (k = 2..4, toggle, good_cgs <= 0):
    - cggood -> SYNC_ACQUIRED_kA with good_cgs <= 1.
    - cgbad -> SYNC_ACQUIRED_k+1, or LOSS_OF_SYNC when k = 4.
  - SYNC_ACQUIRED_kA (toggle):
    - cgbad -> SYNC_ACQUIRED_k+1, or LOSS_OF_SYNC when k = 4.
    - cggood with good_cgs == GOOD_CGS_TARGET -> SYNC_ACQUIRED_k-1.
    - cggood otherwise -> stay with good_cgs + 1.
- signal_detect = 0 overrides every transition -> LOSS_OF_SYNC (same cycle's X still emitted, rx_even toggled).
- Illegal or unencoded state -> LOSS_OF_SYNC.
- Running disparity is not checked; only table membership counts.
- good_cgs saturates and never wraps.

Optional Feature:
- Macro PCS_RX_SYNC_STATS_EN.
- Defined: adds an input stats_clear and two outputs.
  - bad_cg_count[15:0]: saturating, +1 per cgbad while in SYNC_ACQUIRED_*.
  - los_count[7:0]: saturating, +1 per SYNC_ACQUIRED_* -> LOSS_OF_SYNC transition.
  - Both clear on reset or stats_clear; a clear in the same cycle as an increment wins.
- Undefined: these ports and registers are absent; core behaviour is identical.

Decomposition:
- Shared package/include holds:
  - the 10b code-group table constants (K28.5, D16.2, D21.5, ...).
  - the comma pattern constants.
  - the one-hot state encodings.
- One natural sub-module, pcs_cg_classify: combinational, X -> {valid, comma, is_data}; reused later by the transmit-side checker.

Test Plan:
- Reset then pairs K28.5, D16.2 ×3 with signal_detect = 1:
  - sync_status stays 0 through the 5th code-group.
  - sync_status rises 1 cycle after the 6th code-group (D16.2).
  - SUDI[0] pattern is 1,0,1,0,1,0.
- In SYNC_ACQUIRED_1, K28.5 arriving with rx_even == 1 (odd alignment): state goes to SYNC_ACQUIRED_2; sync_status stays 1.
- From SYNC_ACQUIRED_1: one invalid code-group 10'h000 then four good D16.2 -> back to SYNC_ACQUIRED_1. Four invalid code-groups in a row -> sync_status = 0 one cycle after the 4th.
- signal_detect dropped for one cycle while synced -> sync_status = 0 next cycle. Re-acquisition requires a full new 6-code-group comma sequence.
- Reset asserted during ACQUIRE_SYNC_2 -> next cycle SUDI = 0, sync_status = 0. A following D16.2 without a comma leaves the block in LOSS_OF_SYNC.
- With PCS_RX_SYNC_STATS_EN: 3 bad code-groups while synced -> bad_cg_count = 3. Forced loss -> los_count = 1. stats_clear -> both 0 next cycle.

Source files
------------

// File: rtl/pcs_rx_sync_pkg.sv
// pcs_rx_sync_pkg: shared definitions for the 1000BASE-X PCS receive sync block.
//   - 10b code-group constants recognised as valid (running disparity is ignored, so both
//     disparity variants of each code-group are listed).
//   - comma pattern constants (bits [9:3] of a comma-bearing code-group).
//   - one-hot state encoding of the synchronization FSM plus state-group helpers.
// Bit 9 of every code-group is 'a', bit 0 is 'j'.
package pcs_rx_sync_pkg;

  // Control code-groups (commas).
  localparam logic [9:0] K28p5Neg = 10'b0011111010;
  localparam logic [9:0] K28p5Pos = 10'b1100000101;
  localparam logic [9:0] K28p1Neg = 10'b0011111001;
  localparam logic [9:0] K28p1Pos = 10'b1100000110;

  // Data code-groups.
  localparam logic [9:0] D16p2Neg = 10'b0110110101;
  localparam logic [9:0] D16p2Pos = 10'b1001000101;
  localparam logic [9:0] D21p5    = 10'b1010101010;
  localparam logic [9:0] D5p6     = 10'b1010010110;

  // Seven-bit comma sequences, both polarities.
  localparam logic [6:0] CommaNeg = 7'b0011111;
  localparam logic [6:0] CommaPos = 7'b1100000;

  typedef enum logic [12:0] {
    StLossOfSync     = 13'b0000000000001,
    StCommaDetect1   = 13'b0000000000010,
    StCommaDetect2   = 13'b0000000000100,
    StCommaDetect3   = 13'b0000000001000,
    StAcquireSync1   = 13'b0000000010000,
    StAcquireSync2   = 13'b0000000100000,
    StSyncAcquired1  = 13'b0000001000000,
    StSyncAcquired2  = 13'b0000010000000,
    StSyncAcquired2A = 13'b0000100000000,
    StSyncAcquired3  = 13'b0001000000000,
    StSyncAcquired3A = 13'b0010000000000,
    StSyncAcquired4  = 13'b0100000000000,
    StSyncAcquired4A = 13'b1000000000000
  } sync_state_e;

  function automatic logic is_synced(sync_state_e s);
    return s inside {StSyncAcquired1, StSyncAcquired2, StSyncAcquired2A, StSyncAcquired3,
                     StSyncAcquired3A, StSyncAcquired4, StSyncAcquired4A};
  endfunction

  function automatic logic is_comma_detect(sync_state_e s);
    return s inside {StCommaDetect1, StCommaDetect2, StCommaDetect3};
  endfunction

endpackage

// File: rtl/pcs_cg_classify.sv
// pcs_cg_classify: combinational 10b code-group classifier.
// Ports:
//   code_group [9:0] in  : code-group, bit 9 = a, bit 0 = j
//   valid            out : code-group is in the shared code table
//   comma            out : bits [9:3] hold a comma sequence (either polarity)
//   is_data          out : valid data code-group
module pcs_cg_classify
  import pcs_rx_sync_pkg::*;
(
  input  logic [9:0] code_group,
  output logic       valid,
  output logic       comma,
  output logic       is_data
);

  always_comb begin
    valid   = 1'b0;
    is_data = 1'b0;
    case (code_group)
      K28p5Neg, K28p5Pos, K28p1Neg, K28p1Pos: valid = 1'b1;
      D16p2Neg, D16p2Pos, D21p5, D5p6: begin
        valid   = 1'b1;
        is_data = 1'b1;
      end
      default: ;
    endcase
  end

  assign comma = (code_group[9:3] == CommaNeg) || (code_group[9:3] == CommaPos);

endmodule

// File: rtl/pcs_rx_sync.sv
// pcs_rx_sync: 1000BASE-X PCS receive code-group synchronization.
// Runs comma alignment, even/odd tracking and loss-of-sync hysteresis; one code-group per
// clock, outputs registered with one cycle of latency.
// Ports:
//   clk, reset (synchronous, active high)
//   rx_code_group [9:0] in  : received code-group
//   signal_detect       in  : PMD signal present; low forces loss of sync
//   SUDI [10:0]         out : {code_group, rx_even}
//   sync_status         out : 1 while in any SYNC_ACQUIRED state
// Optional (macro PCS_RX_SYNC_STATS_EN):
//   stats_clear         in  : clears both counters
//   bad_cg_count [15:0] out : saturating count of bad code-groups seen while synced
//   los_count [7:0]     out : saturating count of synced -> loss-of-sync transitions
module pcs_rx_sync
  import pcs_rx_sync_pkg::*;
#(
  parameter int unsigned GOOD_CGS_TARGET = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  rx_code_group,
  input  logic        signal_detect,
  output logic [10:0] SUDI,
  output logic        sync_status
`ifdef PCS_RX_SYNC_STATS_EN
  ,
  input  logic        stats_clear,
  output logic [15:0] bad_cg_count,
  output logic [7:0]  los_count
`endif
);

  localparam int unsigned GcW = (GOOD_CGS_TARGET < 2) ? 1 : $clog2(GOOD_CGS_TARGET + 1);
  localparam logic [GcW-1:0] GcTarget = GcW'(GOOD_CGS_TARGET);
  localparam logic [GcW-1:0] GcOne    = GcW'(1);

  sync_state_e    state_q, state_d;
  logic           rx_even_q, rx_even_d;
  logic [GcW-1:0] good_cgs_q, good_cgs_d;
  logic           cg_valid, cg_comma, cg_data;
  logic           cgbad, cggood;

  pcs_cg_classify u_classify (
    .code_group (rx_code_group),
    .valid      (cg_valid),
    .comma      (cg_comma),
    .is_data    (cg_data)
  );

  // A comma landing on an odd position is treated as a bad code-group.
  assign cgbad  = !cg_valid || (cg_comma && rx_even_q);
  assign cggood = !cgbad;

  always_comb begin
    state_d    = state_q;
    good_cgs_d = '0;
    unique case (state_q)
      StLossOfSync:   if (cg_comma) state_d = StCommaDetect1;
      StCommaDetect1: state_d = cg_data ? StAcquireSync1 : StLossOfSync;
      StCommaDetect2: state_d = cg_data ? StAcquireSync2 : StLossOfSync;
      StCommaDetect3: state_d = cg_data ? StSyncAcquired1 : StLossOfSync;
      StAcquireSync1: begin
        if (cgbad)                      state_d = StLossOfSync;
        else if (cg_comma && !rx_even_q) state_d = StCommaDetect2;
      end
      StAcquireSync2: begin
        if (cgbad)                      state_d = StLossOfSync;
        else if (cg_comma && !rx_even_q) state_d = StCommaDetect3;
      end
      StSyncAcquired1: if (cgbad) state_d = StSyncAcquired2;
      StSyncAcquired2: begin
        if (cgbad) state_d = StSyncAcquired3;
        else begin
          state_d    = StSyncAcquired2A;
          good_cgs_d = GcOne;
        end
      end
      StSyncAcquired3: begin
        if (cgbad) state_d = StSyncAcquired4;
        else begin
          state_d    = StSyncAcquired3A;
          good_cgs_d = GcOne;
        end
      end
      StSyncAcquired4: begin
        if (cgbad) state_d = StLossOfSync;
        else begin
          state_d    = StSyncAcquired4A;
          good_cgs_d = GcOne;
        end
      end
      StSyncAcquired2A: begin
        if (cgbad)                         state_d = StSyncAcquired3;
        else if (good_cgs_q == GcTarget)   state_d = StSyncAcquired1;
        else if (good_cgs_q != '1)         good_cgs_d = good_cgs_q + GcOne;
        else                               good_cgs_d = good_cgs_q;
      end
      StSyncAcquired3A: begin
        if (cgbad)                         state_d = StSyncAcquired4;
        else if (good_cgs_q == GcTarget)   state_d = StSyncAcquired2;
        else if (good_cgs_q != '1)         good_cgs_d = good_cgs_q + GcOne;
        else                               good_cgs_d = good_cgs_q;
      end
      StSyncAcquired4A: begin
        if (cgbad)                         state_d = StLossOfSync;
        else if (good_cgs_q == GcTarget)   state_d = StSyncAcquired3;
        else if (good_cgs_q != '1)         good_cgs_d = good_cgs_q + GcOne;
        else                               good_cgs_d = good_cgs_q;
      end
      default: state_d = StLossOfSync;
    endcase

    if (!signal_detect) begin
      state_d    = StLossOfSync;
      good_cgs_d = '0;
    end

    // rx_even is an entry action of the next state: comma-detect forces even, all else toggle.
    rx_even_d = is_comma_detect(state_d) ? 1'b1 : !rx_even_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StLossOfSync;
      rx_even_q   <= 1'b0;
      good_cgs_q  <= '0;
      SUDI        <= '0;
      sync_status <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_even_q   <= rx_even_d;
      good_cgs_q  <= good_cgs_d;
      SUDI        <= {rx_code_group, rx_even_d};
      sync_status <= is_synced(state_d);
    end
  end

`ifdef PCS_RX_SYNC_STATS_EN
  logic was_synced;
  assign was_synced = is_synced(state_q);

  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      bad_cg_count <= '0;
      los_count    <= '0;
    end else begin
      if (was_synced && cgbad && (bad_cg_count != '1)) bad_cg_count <= bad_cg_count + 16'd1;
      if (was_synced && (state_d == StLossOfSync) && (los_count != '1)) begin
        los_count <= los_count + 8'd1;
      end
    end
  end
`endif

endmodule
